// File: rtl/ofs_pkg.sv
// ofs_pkg: shared widths and issue-slot record for the operand fetch scoreboard
package ofs_pkg;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int RIDX = 5;
  typedef struct packed {
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [RIDX-1:0] rd;
    logic            rd_wen;
  } ex_slot_t;
endpackage

// File: rtl/operand_fetch_scoreboard_if.sv
// operand_fetch_scoreboard_if: decode, register bank, writeback and execute signals
interface operand_fetch_scoreboard_if;
  import ofs_pkg::*;
  logic            dec_valid;
  logic            dec_ready;
  logic [RIDX-1:0] dec_rs1;
  logic [RIDX-1:0] dec_rs2;
  logic [RIDX-1:0] dec_rd;
  logic            dec_rd_wen;
  logic [RIDX-1:0] rf_a;
  logic [RIDX-1:0] rf_b;
  logic [XLEN-1:0] rf_dataA;
  logic [XLEN-1:0] rf_dataB;
  logic [RIDX-1:0] rf_c;
  logic            rf_w;
  logic [XLEN-1:0] rf_dataC;
  logic            wb_valid;
  logic [RIDX-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_op_a;
  logic [XLEN-1:0] ex_op_b;
  logic [RIDX-1:0] ex_rd;
  logic            ex_rd_wen;
  logic            sb_err;
  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_rd_wen, rf_dataA, rf_dataB,
           wb_valid, wb_rd, wb_data, ex_ready,
    output dec_ready, rf_a, rf_b, rf_c, rf_w, rf_dataC,
           ex_valid, ex_op_a, ex_op_b, ex_rd, ex_rd_wen, sb_err
  );
  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_rd_wen, rf_dataA, rf_dataB,
           wb_valid, wb_rd, wb_data, ex_ready,
    input  dec_ready, rf_a, rf_b, rf_c, rf_w, rf_dataC,
           ex_valid, ex_op_a, ex_op_b, ex_rd, ex_rd_wen, sb_err
  );
endinterface

// File: rtl/ofs_scoreboard.sv
// ofs_scoreboard: busy bits, RAW/WAW hazard check and sticky error; OFS_WB_BYPASS_EN unmasks sources being written back
module ofs_scoreboard
  import ofs_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [RIDX-1:0] set_idx,
  input  logic            clr_en,
  input  logic [RIDX-1:0] clr_idx,
  input  logic [RIDX-1:0] rs1,
  input  logic [RIDX-1:0] rs2,
  input  logic [RIDX-1:0] rd,
  input  logic            rd_wen,
  output logic            hazard,
  output logic            sb_err
);
  logic [NREG-1:0] busy_q, busy_d;
  logic            sb_err_q, sb_err_d;
  logic            rs1_busy, rs2_busy;
`ifdef OFS_WB_BYPASS_EN
  assign rs1_busy = busy_q[rs1] && !(clr_en && clr_idx == rs1);
  assign rs2_busy = busy_q[rs2] && !(clr_en && clr_idx == rs2);
`else
  assign rs1_busy = busy_q[rs1];
  assign rs2_busy = busy_q[rs2];
`endif
  assign hazard = rs1_busy || rs2_busy || (rd_wen && busy_q[rd]);
  assign sb_err = sb_err_q;
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    sb_err_d = sb_err_q || (clr_en && !busy_q[clr_idx]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= '0;
      sb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      sb_err_q <= sb_err_d;
    end
  end
endmodule

// File: rtl/operand_fetch_scoreboard.sv
// operand_fetch_scoreboard: operand fetch into a registered issue slot with hazard stalls; OFS_WB_BYPASS_EN forwards wb_data to operands
module operand_fetch_scoreboard
  import ofs_pkg::*;
(
  input logic clk,
  input logic rst,
  operand_fetch_scoreboard_if.slave bus
);
  ex_slot_t        slot_q, slot_d;
  logic            ex_valid_q, ex_valid_d;
  logic            hazard, slot_free, issue;
  logic [XLEN-1:0] op_a, op_b;
  assign bus.rf_a     = bus.dec_rs1;
  assign bus.rf_b     = bus.dec_rs2;
  assign bus.rf_c     = bus.wb_rd;
  assign bus.rf_w     = bus.wb_valid;
  assign bus.rf_dataC = bus.wb_data;
  assign slot_free     = !ex_valid_q || bus.ex_ready;
  assign bus.dec_ready = slot_free && !hazard;
  assign issue         = bus.dec_valid && bus.dec_ready;
`ifdef OFS_WB_BYPASS_EN
  assign op_a = (bus.wb_valid && bus.wb_rd == bus.dec_rs1) ? bus.wb_data : bus.rf_dataA;
  assign op_b = (bus.wb_valid && bus.wb_rd == bus.dec_rs2) ? bus.wb_data : bus.rf_dataB;
`else
  assign op_a = bus.rf_dataA;
  assign op_b = bus.rf_dataB;
`endif
  always_comb begin
    slot_d     = issue ? ex_slot_t'{op_a, op_b, bus.dec_rd, bus.dec_rd_wen} : slot_q;
    ex_valid_d = issue || (ex_valid_q && !slot_free);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q     <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      ex_valid_q <= ex_valid_d;
    end
  end
  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_op_a   = slot_q.op_a;
  assign bus.ex_op_b   = slot_q.op_b;
  assign bus.ex_rd     = slot_q.rd;
  assign bus.ex_rd_wen = slot_q.rd_wen;
  ofs_scoreboard u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (issue && bus.dec_rd_wen),
    .set_idx (bus.dec_rd),
    .clr_en  (bus.wb_valid),
    .clr_idx (bus.wb_rd),
    .rs1     (bus.dec_rs1),
    .rs2     (bus.dec_rs2),
    .rd      (bus.dec_rd),
    .rd_wen  (bus.dec_rd_wen),
    .hazard  (hazard),
    .sb_err  (bus.sb_err)
  );
endmodule

// File: tb/tb_operand_fetch_scoreboard.sv
// tb_operand_fetch_scoreboard: bank model plus issue-slot scoreboard; honours OFS_WB_BYPASS_EN
module tb_operand_fetch_scoreboard;
  import ofs_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  operand_fetch_scoreboard_if ifc();
  operand_fetch_scoreboard dut (.clk(clk), .rst(rst), .bus(ifc.slave));

  logic [XLEN-1:0] bank [NREG];
  bit bank_init = 1'b0;
  always @(posedge clk) begin
    if (!bank_init) begin
      for (int i = 0; i < NREG; i++) bank[i] <= XLEN'(i);
      bank_init <= 1'b1;
    end else if (ifc.rf_w) bank[ifc.rf_c] <= ifc.rf_dataC;
  end
  assign ifc.rf_dataA = bank[ifc.rf_a];
  assign ifc.rf_dataB = bank[ifc.rf_b];

  int n_cmp = 0;
  int n_bad = 0;
  ex_slot_t exp_q[$];
  logic [XLEN-1:0] mdl [NREG];

  // Each consumed slot must match the oldest accepted instruction's expected record.
  always @(negedge clk) begin
    if (ifc.ex_valid === 1'b1 && ifc.ex_ready === 1'b1) begin
      ex_slot_t g, e;
      g = ex_slot_t'{ifc.ex_op_a, ifc.ex_op_b, ifc.ex_rd, ifc.ex_rd_wen};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL slot_unexpected got a=%h b=%h rd=%0d wen=%b", g.op_a, g.op_b, g.rd, g.rd_wen);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          n_bad++;
          $display("FAIL slot got a=%h b=%h rd=%0d wen=%b exp a=%h b=%h rd=%0d wen=%b",
                   g.op_a, g.op_b, g.rd, g.rd_wen, e.op_a, e.op_b, e.rd, e.rd_wen);
        end
      end
    end
  end

  function automatic logic [XLEN-1:0] exp_op(input logic [RIDX-1:0] r);
`ifdef OFS_WB_BYPASS_EN
    return (ifc.wb_valid && ifc.wb_rd == r) ? ifc.wb_data : mdl[r];
`else
    return mdl[r];
`endif
  endfunction

  task automatic tick(input bit push);
    if (push) exp_q.push_back(ex_slot_t'{exp_op(ifc.dec_rs1), exp_op(ifc.dec_rs2), ifc.dec_rd, ifc.dec_rd_wen});
    @(posedge clk);
    if (ifc.wb_valid) mdl[ifc.wb_rd] = ifc.wb_data;
    #1;
  endtask

  task automatic drive_dec(input logic v, input int rs1, input int rs2, input int rd, input logic wen);
    ifc.dec_valid  = v;
    ifc.dec_rs1    = RIDX'(rs1);
    ifc.dec_rs2    = RIDX'(rs2);
    ifc.dec_rd     = RIDX'(rd);
    ifc.dec_rd_wen = wen;
    #1;
  endtask

  task automatic drive_wb(input logic v, input int rd, input logic [XLEN-1:0] d);
    ifc.wb_valid = v;
    ifc.wb_rd    = RIDX'(rd);
    ifc.wb_data  = d;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ifc.ex_ready = 1'b1;
    drive_dec(1'b0, 0, 0, 0, 1'b0);
    drive_wb(1'b0, 0, '0);
    tick(1'b0);
    tick(1'b0);
    rst = 1'b0;
    #1;
    n_cmp++; if (ifc.ex_valid !== 1'b0) begin n_bad++; $display("FAIL rst_ex_valid got %b exp 0", ifc.ex_valid); end
    n_cmp++; if (ifc.ex_op_a !== '0) begin n_bad++; $display("FAIL rst_op_a got %h exp 0", ifc.ex_op_a); end
    n_cmp++; if (ifc.ex_op_b !== '0) begin n_bad++; $display("FAIL rst_op_b got %h exp 0", ifc.ex_op_b); end
    n_cmp++; if (ifc.ex_rd !== '0 || ifc.ex_rd_wen !== 1'b0) begin n_bad++; $display("FAIL rst_rd got %0d/%b exp 0/0", ifc.ex_rd, ifc.ex_rd_wen); end
    n_cmp++; if (ifc.sb_err !== 1'b0) begin n_bad++; $display("FAIL rst_sb_err got %b exp 0", ifc.sb_err); end
    n_cmp++; if (ifc.dec_ready !== 1'b1) begin n_bad++; $display("FAIL rst_dec_ready got %b exp 1", ifc.dec_ready); end
  endtask

  task automatic test_issue;
    drive_dec(1'b1, 3, 5, 7, 1'b1);
    n_cmp++; if (ifc.rf_a !== 5'd3 || ifc.rf_b !== 5'd5) begin n_bad++; $display("FAIL issue_rf_addr got %0d/%0d exp 3/5", ifc.rf_a, ifc.rf_b); end
    n_cmp++; if (ifc.dec_ready !== 1'b1) begin n_bad++; $display("FAIL issue_ready got %b exp 1", ifc.dec_ready); end
    tick(1'b1);
    drive_dec(1'b0, 0, 0, 0, 1'b0);
    n_cmp++; if (ifc.ex_valid !== 1'b1) begin n_bad++; $display("FAIL issue_ex_valid got %b exp 1", ifc.ex_valid); end
    n_cmp++; if (ifc.ex_op_a !== 64'd3 || ifc.ex_op_b !== 64'd5) begin n_bad++; $display("FAIL issue_ops got %h/%h exp 3/5", ifc.ex_op_a, ifc.ex_op_b); end
    tick(1'b0);
    n_cmp++; if (ifc.ex_valid !== 1'b0) begin n_bad++; $display("FAIL issue_drain got %b exp 0", ifc.ex_valid); end
  endtask

  task automatic test_raw;
    drive_dec(1'b1, 7, 0, 1, 1'b0);
    n_cmp++; if (ifc.dec_ready !== 1'b0) begin n_bad++; $display("FAIL raw_stall got %b exp 0", ifc.dec_ready); end
    tick(1'b0);
    n_cmp++; if (ifc.dec_ready !== 1'b0 || ifc.ex_valid !== 1'b0) begin n_bad++; $display("FAIL raw_stall2 got %b/%b exp 0/0", ifc.dec_ready, ifc.ex_valid); end
    drive_wb(1'b1, 7, 64'hAA);
    n_cmp++; if (ifc.rf_w !== 1'b1 || ifc.rf_c !== 5'd7 || ifc.rf_dataC !== 64'hAA) begin n_bad++; $display("FAIL wb_pass got %b/%0d/%h exp 1/7/aa", ifc.rf_w, ifc.rf_c, ifc.rf_dataC); end
`ifdef OFS_WB_BYPASS_EN
    n_cmp++; if (ifc.dec_ready !== 1'b1) begin n_bad++; $display("FAIL raw_bypass_ready got %b exp 1", ifc.dec_ready); end
    tick(1'b1);
    drive_wb(1'b0, 0, '0);
`else
    n_cmp++; if (ifc.dec_ready !== 1'b0) begin n_bad++; $display("FAIL raw_wb_cycle got %b exp 0", ifc.dec_ready); end
    tick(1'b0);
    drive_wb(1'b0, 0, '0);
    n_cmp++; if (ifc.dec_ready !== 1'b1) begin n_bad++; $display("FAIL raw_after_wb got %b exp 1", ifc.dec_ready); end
    tick(1'b1);
`endif
    drive_dec(1'b0, 0, 0, 0, 1'b0);
    n_cmp++; if (ifc.ex_valid !== 1'b1 || ifc.ex_op_a !== 64'hAA) begin n_bad++; $display("FAIL raw_op got %b/%h exp 1/aa", ifc.ex_valid, ifc.ex_op_a); end
    tick(1'b0);
  endtask

  task automatic test_waw;
    drive_dec(1'b1, 1, 2, 9, 1'b1);
    tick(1'b1);
    drive_dec(1'b1, 10, 11, 9, 1'b1);
    n_cmp++; if (ifc.dec_ready !== 1'b0) begin n_bad++; $display("FAIL waw_stall got %b exp 0", ifc.dec_ready); end
    tick(1'b0);
    drive_wb(1'b1, 9, 64'h99);
    n_cmp++; if (ifc.dec_ready !== 1'b0) begin n_bad++; $display("FAIL waw_wb_cycle got %b exp 0", ifc.dec_ready); end
    tick(1'b0);
    drive_wb(1'b0, 0, '0);
    n_cmp++; if (ifc.dec_ready !== 1'b1) begin n_bad++; $display("FAIL waw_release got %b exp 1", ifc.dec_ready); end
    tick(1'b1);
    drive_dec(1'b0, 0, 0, 0, 1'b0);
    tick(1'b0);
  endtask

  task automatic test_back_to_back;
    ifc.ex_ready = 1'b0;
    drive_dec(1'b1, 13, 14, 15, 1'b0);
    tick(1'b1);
    drive_dec(1'b1, 16, 17, 18, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (ifc.dec_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready[%0d] got %b exp 0", i, ifc.dec_ready); end
      n_cmp++; if (ifc.ex_valid !== 1'b1 || ifc.ex_op_a !== 64'd13 || ifc.ex_op_b !== 64'd14 || ifc.ex_rd !== 5'd15)
        begin n_bad++; $display("FAIL bp_hold[%0d] got %b/%h/%h/%0d exp 1/d/e/15", i, ifc.ex_valid, ifc.ex_op_a, ifc.ex_op_b, ifc.ex_rd); end
      tick(1'b0);
    end
    ifc.ex_ready = 1'b1;
    #1;
    n_cmp++; if (ifc.dec_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release got %b exp 1", ifc.dec_ready); end
    tick(1'b1);
    drive_dec(1'b0, 0, 0, 0, 1'b0);
    n_cmp++; if (ifc.ex_valid !== 1'b1 || ifc.ex_op_a !== 64'd16) begin n_bad++; $display("FAIL bp_next got %b/%h exp 1/10", ifc.ex_valid, ifc.ex_op_a); end
    tick(1'b0);
  endtask

  task automatic test_sb_err;
    drive_wb(1'b1, 12, 64'h1234);
    n_cmp++; if (ifc.rf_w !== 1'b1 || ifc.rf_c !== 5'd12 || ifc.sb_err !== 1'b0) begin n_bad++; $display("FAIL err_pre got %b/%0d/%b exp 1/12/0", ifc.rf_w, ifc.rf_c, ifc.sb_err); end
    tick(1'b0);
    drive_wb(1'b0, 0, '0);
    n_cmp++; if (ifc.sb_err !== 1'b1) begin n_bad++; $display("FAIL err_set got %b exp 1", ifc.sb_err); end
    drive_dec(1'b1, 12, 12, 20, 1'b0);
    n_cmp++; if (ifc.dec_ready !== 1'b1) begin n_bad++; $display("FAIL err_read_ready got %b exp 1", ifc.dec_ready); end
    tick(1'b1);
    drive_dec(1'b0, 0, 0, 0, 1'b0);
    tick(1'b0);
    tick(1'b0);
    n_cmp++; if (ifc.sb_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b exp 1", ifc.sb_err); end
  endtask

  task automatic test_rst_mid;
    ifc.ex_ready = 1'b0;
    drive_dec(1'b1, 0, 1, 4, 1'b1);
    n_cmp++; if (ifc.dec_ready !== 1'b1) begin n_bad++; $display("FAIL mid_issue got %b exp 1", ifc.dec_ready); end
    tick(1'b0);
    drive_dec(1'b1, 4, 0, 21, 1'b0);
    n_cmp++; if (ifc.ex_valid !== 1'b1 || ifc.dec_ready !== 1'b0) begin n_bad++; $display("FAIL mid_held got %b/%b exp 1/0", ifc.ex_valid, ifc.dec_ready); end
    rst = 1'b1;
    tick(1'b0);
    rst = 1'b0;
    #1;
    n_cmp++; if (ifc.ex_valid !== 1'b0 || ifc.sb_err !== 1'b0) begin n_bad++; $display("FAIL mid_rst got %b/%b exp 0/0", ifc.ex_valid, ifc.sb_err); end
    n_cmp++; if (ifc.dec_ready !== 1'b1) begin n_bad++; $display("FAIL mid_busy_clear got %b exp 1", ifc.dec_ready); end
    ifc.ex_ready = 1'b1;
    tick(1'b1);
    drive_dec(1'b0, 0, 0, 0, 1'b0);
    n_cmp++; if (ifc.ex_valid !== 1'b1 || ifc.ex_op_a !== 64'd4) begin n_bad++; $display("FAIL mid_reissue got %b/%h exp 1/4", ifc.ex_valid, ifc.ex_op_a); end
    drive_wb(1'b1, 4, 64'h44);
    tick(1'b0);
    drive_wb(1'b0, 0, '0);
    n_cmp++; if (ifc.sb_err !== 1'b1) begin n_bad++; $display("FAIL mid_stale_wb got %b exp 1", ifc.sb_err); end
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) mdl[i] = XLEN'(i);
    test_reset();
    test_issue();
    test_raw();
    test_waw();
    test_back_to_back();
    test_sb_err();
    test_rst_mid();
    tick(1'b0);
    tick(1'b0);
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL leftover got %0d exp 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
